multi_circle_gen: RTL and testbench

Streaming midpoint-circle point generator. It is the parametrised successor of the single triple-circle generator. It emits one (x, y) point per accepted cycle for RINGS concentric circles: radius, radius+ring_step, and so on. An octant mask selects which of the 8 symmetric points are emitted. It sits behind the generator-style start/done/valid/ready interface and feeds pixel writers or a framebuffer arbiter.

---
 rtl/multi_circle_gen_if.sv | 30 +++
 rtl/multi_circle_gen.sv | 169 ++++++++++++++++
 tb/tb_multi_circle_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_circle_gen_if.sv
// Handshake and argument bundle between a circle generator and its point consumer.
// The master drives start/ready and the run arguments; the slave returns done/valid and the point.
interface multi_circle_gen_if #(
    parameter int WIDTH     = 32,
    parameter int RING_BITS = 4
);
    logic                        _start;
    logic                        _ready;
    logic signed [WIDTH-1:0]     centre_x;
    logic signed [WIDTH-1:0]     centre_y;
    logic signed [WIDTH-1:0]     radius;
    logic signed [WIDTH-1:0]     ring_step;
    logic        [RING_BITS-1:0] ring_count;
    logic        [7:0]           octant_mask;
    logic                        _done;
    logic                        _valid;
    logic signed [WIDTH-1:0]     _out_0;
    logic signed [WIDTH-1:0]     _out_1;
    logic        [RING_BITS-1:0] _out_2;

    modport master (
        output _start, _ready, centre_x, centre_y, radius, ring_step, ring_count, octant_mask,
        input  _done, _valid, _out_0, _out_1, _out_2
    );

    modport slave (
        input  _start, _ready, centre_x, centre_y, radius, ring_step, ring_count, octant_mask,
        output _done, _valid, _out_0, _out_1, _out_2
    );
endinterface

// File: rtl/multi_circle_gen.sv
// Midpoint-circle point generator for several concentric rings, one point per accepted cycle,
// with an octant mask selecting which of the eight symmetric points are emitted.
module multi_circle_gen #(
    parameter int WIDTH     = 32,
    parameter int RING_BITS = 4
) (
    input  logic              _clock,
    input  logic              _reset_n,
    multi_circle_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, EMIT, DONE} state_t;

    localparam logic signed [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH+2:0] ONE_C    = {{(WIDTH+2){1'b0}}, 1'b1};
    localparam logic [RING_BITS-1:0]    RING_ONE = {{(RING_BITS-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d, rad_q, rad_d, step_q, step_d;
    logic signed [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic signed [WIDTH+2:0] crit_q, crit_d;
    logic [RING_BITS-1:0]    cnt_q, cnt_d, ring_q, ring_d;
    logic [7:0]              mask_q, mask_d;
    logic [2:0]              p_q, p_d;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    // Sum in WIDTH+1 bits, then wrap back to WIDTH.
    function automatic logic signed [WIDTH-1:0] wrap_sum(input logic signed [WIDTH-1:0] a,
                                                         input logic signed [WIDTH-1:0] b,
                                                         input logic                    sub);
        logic signed [WIDTH:0] s;
        if (sub) s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        else     s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        return s[WIDTH-1:0];
    endfunction

    logic                    vld, fire, advance, has_next;
    logic                    swap, neg_x, neg_y;
    logic signed [WIDTH-1:0] dx, dy, ox_n, oy_n;
    logic signed [WIDTH+2:0] oxe, oye, rade, crit_n;
    logic [7:0]              upper;
    logic [2:0]              next_p;

    // Slot p in binary: swap axes for 1,2,5,6; negate x for 2..5; negate y for 4..7.
    assign swap  = p_q[0] ^ p_q[1];
    assign neg_x = p_q[1] ^ p_q[2];
    assign neg_y = p_q[2];
    assign dx    = swap ? oy_q : ox_q;
    assign dy    = swap ? ox_q : oy_q;

    assign vld         = (state_q == EMIT) && (mask_q != 8'd0);
    assign bus._valid  = vld;
    assign bus._done   = (state_q == DONE);
    assign bus._out_0  = vld ? wrap_sum(cx_q, dx, neg_x) : '0;
    assign bus._out_1  = vld ? wrap_sum(cy_q, dy, neg_y) : '0;
    assign bus._out_2  = vld ? ring_q : '0;

    assign upper    = mask_q & (8'hFE << p_q);
    assign has_next = |upper;
    assign next_p   = lowest_bit(upper);
    assign fire     = vld && bus._ready;
    assign advance  = (state_q == EMIT) && ((mask_q == 8'd0) || (fire && !has_next));

    assign ox_n   = ox_q + ONE_W;
    assign oy_n   = crit_q[WIDTH+2] ? oy_q : oy_q - ONE_W;
    assign oxe    = {{3{ox_n[WIDTH-1]}}, ox_n};
    assign oye    = {{3{oy_n[WIDTH-1]}}, oy_n};
    assign rade   = {{3{rad_q[WIDTH-1]}}, rad_q};
    assign crit_n = crit_q[WIDTH+2] ? crit_q + oxe + oxe + ONE_C
                                    : crit_q + (oxe - oye) + (oxe - oye) + ONE_C;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        rad_d   = rad_q;
        step_d  = step_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        cnt_d   = cnt_q;
        ring_d  = ring_q;
        mask_d  = mask_q;
        p_d     = p_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus._start) begin
                    cx_d    = bus.centre_x;
                    cy_d    = bus.centre_y;
                    rad_d   = bus.radius;
                    step_d  = bus.ring_step;
                    cnt_d   = bus.ring_count;
                    mask_d  = bus.octant_mask;
                    ring_d  = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (ring_q == cnt_q) begin
                    state_d = DONE;
                end else if (rad_q[WIDTH-1]) begin
                    // A negative radius has an empty loop: skip straight to the next ring.
                    ring_d = ring_q + RING_ONE;
                    rad_d  = rad_q + step_q;
                end else begin
                    ox_d    = '0;
                    oy_d    = rad_q;
                    crit_d  = ONE_C - rade;
                    p_d     = lowest_bit(mask_q);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (advance) begin
                    ox_d   = ox_n;
                    oy_d   = oy_n;
                    crit_d = crit_n;
                    p_d    = lowest_bit(mask_q);
                    if (oy_n < ox_n) begin
                        ring_d  = ring_q + RING_ONE;
                        rad_d   = rad_q + step_q;
                        state_d = INIT;
                    end
                end else if (fire) begin
                    p_d = next_p;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            cx_q   <= '0;
            cy_q   <= '0;
            rad_q  <= '0;
            step_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            crit_q <= '0;
            cnt_q  <= '0;
            ring_q <= '0;
            mask_q <= '0;
            p_q    <= '0;
        end else begin
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            rad_q  <= rad_d;
            step_q <= step_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            crit_q <= crit_d;
            cnt_q  <= cnt_d;
            ring_q <= ring_d;
            mask_q <= mask_d;
            p_q    <= p_d;
        end
    end
endmodule

// File: tb/tb_multi_circle_gen.sv
// Scoreboard bench for multi_circle_gen: a software midpoint model queues expected points,
// a negedge monitor pops and compares every accepted point.
module tb_multi_circle_gen;
    localparam int W  = 32;
    localparam int RB = 4;

    typedef struct {
        int x;
        int y;
        int ring;
    } pt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_circle_gen_if #(.WIDTH(W), .RING_BITS(RB)) bus ();

    multi_circle_gen #(.WIDTH(W), .RING_BITS(RB)) dut (
        ._clock   (clk),
        ._reset_n (rst_n),
        .bus      (bus)
    );

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  bp    = 1'b0;
    pt_t exp_q[$];
    pt_t obs_q[$];
    int  obs_cyc[$];
    bit  stall_v = 1'b0;
    pt_t hold;

    task automatic chk(input string tag, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic push_pt(input int cx, input int cy, input int ox, input int oy,
                           input int ring, input int s);
        pt_t p;
        case (s)
            0: begin p.x = cx + ox; p.y = cy + oy; end
            1: begin p.x = cx + oy; p.y = cy + ox; end
            2: begin p.x = cx - oy; p.y = cy + ox; end
            3: begin p.x = cx - ox; p.y = cy + oy; end
            4: begin p.x = cx - ox; p.y = cy - oy; end
            5: begin p.x = cx - oy; p.y = cy - ox; end
            6: begin p.x = cx + oy; p.y = cy - ox; end
            default: begin p.x = cx + ox; p.y = cy - oy; end
        endcase
        p.ring = ring;
        exp_q.push_back(p);
    endtask

    task automatic model(input int cx, input int cy, input int r0, input int step,
                         input int cnt, input logic [7:0] mask);
        int r, ox, oy, crit;
        r = r0;
        for (int k = 0; k < cnt; k++) begin
            if (r >= 0) begin
                ox = 0;
                oy = r;
                crit = 1 - r;
                while (oy >= ox) begin
                    for (int s = 0; s < 8; s++)
                        if (mask[s]) push_pt(cx, cy, ox, oy, k, s);
                    ox++;
                    if (crit < 0) crit += 2 * ox + 1;
                    else begin
                        oy--;
                        crit += 2 * (ox - oy) + 1;
                    end
                end
            end
            r += step;
        end
    endtask

    // Leaves the caller at the first negedge after the _start edge.
    task automatic launch(input int cx, input int cy, input int r, input int step,
                          input int cnt, input logic [7:0] mask);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        model(cx, cy, r, step, cnt, mask);
        @(negedge clk);
        bus.centre_x    = cx;
        bus.centre_y    = cy;
        bus.radius      = r;
        bus.ring_step   = step;
        bus.ring_count  = RB'(cnt);
        bus.octant_mask = mask;
        bus._start      = 1'b1;
        @(negedge clk);
        bus._start      = 1'b0;
        bus.centre_x    = $urandom;
        bus.centre_y    = $urandom;
        bus.radius      = $urandom;
        bus.ring_step   = $urandom;
        bus.ring_count  = RB'($urandom);
        bus.octant_mask = 8'($urandom);
    endtask

    task automatic wait_done(input int glitch_at, output int n_done, output int n_first,
                             output int n_last, output int n_valid);
        int n;
        n = 1;
        n_done = -1;
        n_first = -1;
        n_last = -1;
        n_valid = 0;
        while (n < 5000) begin
            if (bus._valid) begin
                n_valid++;
                n_last = n;
                if (n_first < 0) n_first = n;
            end
            if (n == glitch_at) begin
                bus._start     = 1'b1;
                bus.radius     = 3;
                bus.ring_count = 4'd5;
            end else if (n == glitch_at + 1) begin
                bus._start = 1'b0;
            end
            if (bus._done) begin
                n_done = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        chk("done_in_time", n_done >= 0, 1);
        chk("sb_leftover", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (bp) bus._ready = 1'($urandom_range(0, 1));
    end

    initial forever begin
        pt_t cur, e;
        @(negedge clk);
        if (stall_v) begin
            chk("hold_valid", bus._valid, 1);
            chk("hold_x", bus._out_0, hold.x);
            chk("hold_y", bus._out_1, hold.y);
            chk("hold_ring", bus._out_2, hold.ring);
        end
        stall_v = 1'b0;
        if (bus._valid && rst_n) begin
            cur.x    = bus._out_0;
            cur.y    = bus._out_1;
            cur.ring = int'(bus._out_2);
            if (!bus._ready) begin
                stall_v = 1'b1;
                hold    = cur;
            end else begin
                chk("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pt_x", cur.x, e.x);
                    chk("pt_y", cur.y, e.y);
                    chk("pt_ring", cur.ring, e.ring);
                end
                obs_q.push_back(cur);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, bus._valid, 0);
        chk({tag, "_done"}, bus._done, 0);
        chk({tag, "_x"}, bus._out_0, 0);
        chk({tag, "_y"}, bus._out_1, 0);
        chk({tag, "_ring"}, bus._out_2, 0);
    endtask

    initial begin
        int nd, nf, nl, nv;
        bus._start      = 1'b0;
        bus._ready      = 1'b1;
        bus.centre_x    = '0;
        bus.centre_y    = '0;
        bus.radius      = '0;
        bus.ring_step   = '0;
        bus.ring_count  = '0;
        bus.octant_mask = '0;

        repeat (3) @(negedge clk);
        chk_idle_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("post_rst");

        // Single ring, all octants.
        launch(50, 50, 8, 0, 1, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("base_count", obs_q.size(), 48);
        chk("base_p0_x", obs_q[0].x, 50);
        chk("base_p0_y", obs_q[0].y, 58);
        chk("base_p1_x", obs_q[1].x, 58);
        chk("base_p1_y", obs_q[1].y, 50);
        chk("base_p40_x", obs_q[40].x, 55);
        chk("base_p40_y", obs_q[40].y, 56);
        chk("base_latency", nf, 2);
        chk("base_done_gap", nd - nl, 2);

        launch(50, 50, 0, 0, 1, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("r0_count", obs_q.size(), 8);

        launch(50, 50, 1, 0, 1, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("r1_count", obs_q.size(), 8);
        chk("r1_p2_x", obs_q[2].x, 49);
        chk("r1_p2_y", obs_q[2].y, 50);

        // Three rings, octant 0 only; one INIT cycle between rings.
        launch(50, 50, 1, 1, 3, 8'h01);
        wait_done(-10, nd, nf, nl, nv);
        chk("rings_count", obs_q.size(), 6);
        chk("rings_gap01", obs_cyc[1] - obs_cyc[0], 2);
        chk("rings_run12", obs_cyc[2] - obs_cyc[1], 1);
        chk("rings_gap23", obs_cyc[3] - obs_cyc[2], 2);
        chk("rings_last_ring", obs_q[5].ring, 2);

        // Random backpressure.
        bp = 1'b1;
        launch(50, 50, 8, 0, 1, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("bp_count", obs_q.size(), 48);
        @(negedge clk);
        bp = 1'b0;
        bus._ready = 1'b1;

        launch(50, 50, 8, 0, 0, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("cnt0_done_at", nd, 2);
        chk("cnt0_valids", nv, 0);

        launch(50, 50, 8, 0, 1, 8'h00);
        wait_done(-10, nd, nf, nl, nv);
        chk("mask0_done_at", nd, 9);
        chk("mask0_valids", nv, 0);

        // Negative first ring emits nothing; second ring has radius 1.
        launch(-20, 7, -3, 4, 2, 8'h81);
        wait_done(-10, nd, nf, nl, nv);
        chk("neg_count", obs_q.size(), 2);

        // _start during EMIT must be ignored.
        launch(50, 50, 8, 0, 1, 8'hFF);
        wait_done(10, nd, nf, nl, nv);
        chk("glitch_count", obs_q.size(), 48);

        // Asynchronous reset mid-run, then a fresh baseline run.
        launch(50, 50, 8, 0, 1, 8'hFF);
        repeat (10) @(negedge clk);
        chk("pre_rst_valid", bus._valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle_outputs("rst_idle");
        launch(50, 50, 8, 0, 1, 8'hFF);
        wait_done(-10, nd, nf, nl, nv);
        chk("rerun_count", obs_q.size(), 48);
        chk("rerun_p0_y", obs_q[0].y, 58);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
